// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared MODE encodings and MODE-3 state encoding for full_pipe.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

    localparam int MODE_BYPASS   = 0;
    localparam int MODE_BACKWARD = 1;
    localparam int MODE_FORWARD  = 2;
    localparam int MODE_FULL     = 3;

    // State value equals the number of words held, so occ is read straight off it.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } pipe_state_e;

    function automatic logic [1:0] occ_of(input pipe_state_e s);
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : full_pipe_if
// Description : Valid/ready handshake bundle (upstream _f, downstream _b).
// Revision    : 1.0  initial release
// ============================================================================
interface full_pipe_if #(
    parameter int L = 8
);
    logic         valid_f;
    logic         ready_f;
    logic [L-1:0] data_f;
    logic         valid_b;
    logic         ready_b;
    logic [L-1:0] data_b;
    logic [1:0]   occ;

    modport master (
        output valid_f, data_f, ready_b,
        input  ready_f, valid_b, data_b, occ
    );

    modport slave (
        input  valid_f, data_f, ready_b,
        output ready_f, valid_b, data_b, occ
    );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_reg
// Description : Single skid entry (data + valid) with load, unload and clear.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_skid_reg #(
    parameter int L = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         i_clr,
    input  wire logic         i_load,
    input  wire logic         i_unload,
    input  wire logic [L-1:0] i_data,
    output logic [L-1:0]      o_data,
    output logic              o_valid
);

    logic [L-1:0] r_data;
    logic         r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/full_pipe.sv
`default_nettype none
// ============================================================================
// Module      : full_pipe
// Description : Valid/ready pipeline slice: bypass, backward-, forward- or
//               fully-registered. Optional flush input: FULL_PIPE_FLUSH_EN.
// Revision    : 1.0  initial release
// ============================================================================
module full_pipe
    import pipe_pkg::*;
#(
    parameter int L    = 8,
    parameter int MODE = MODE_FULL
) (
    input  wire logic  clk,
    input  wire logic  rst,
`ifdef FULL_PIPE_FLUSH_EN
    input  wire logic  flush,
`endif
    full_pipe_if.slave p
);

    logic w_flush;

`ifdef FULL_PIPE_FLUSH_EN
    assign w_flush = flush;
`else
    assign w_flush = 1'b0;
`endif

    generate
        if (MODE == MODE_BYPASS) begin : g_bypass
            logic w_unused;
            assign w_unused  = ^{clk, rst, w_flush};
            assign p.ready_f = p.ready_b;
            assign p.valid_b = p.valid_f;
            assign p.data_b  = p.data_f;
            assign p.occ     = 2'd0;

        end else if (MODE == MODE_BACKWARD) begin : g_backward
            logic         r_ready_f;
            logic         w_load;
            logic         w_skid_valid;
            logic [L-1:0] w_skid_data;

            // Word accepted while downstream stalls must park in the skid.
            assign w_load = p.valid_f && r_ready_f && !p.ready_b;

            pipe_skid_reg #(.L(L)) u_skid (
                .clk      (clk),
                .rst      (rst),
                .i_clr    (w_flush),
                .i_load   (w_load),
                .i_unload (p.ready_b),
                .i_data   (p.data_f),
                .o_data   (w_skid_data),
                .o_valid  (w_skid_valid)
            );

            always_ff @(posedge clk) begin
                if (rst || w_flush) begin
                    r_ready_f <= 1'b1;
                end else begin
                    r_ready_f <= p.ready_b || (!w_skid_valid && !w_load);
                end
            end

            assign p.ready_f = r_ready_f;
            assign p.valid_b = r_ready_f ? p.valid_f : w_skid_valid;
            assign p.data_b  = r_ready_f ? p.data_f  : w_skid_data;
            assign p.occ     = {1'b0, w_skid_valid};

        end else if (MODE == MODE_FORWARD) begin : g_forward
            logic         r_valid;
            logic [L-1:0] r_data;
            logic         w_ready_f;

            assign w_ready_f = p.ready_b || !r_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_data  <= '0;
                end else if (w_flush) begin
                    r_valid <= 1'b0;
                end else if (p.valid_f && w_ready_f) begin
                    r_valid <= 1'b1;
                    r_data  <= p.data_f;
                end else if (p.ready_b) begin
                    r_valid <= 1'b0;
                end
            end

            assign p.ready_f = w_ready_f;
            assign p.valid_b = r_valid;
            assign p.data_b  = r_data;
            assign p.occ     = {1'b0, r_valid};

        end else begin : g_full
            pipe_state_e  r_state;
            logic         r_ready_f;
            logic         r_valid_b;
            logic [L-1:0] r_data;
            logic         w_in;
            logic         w_out;
            logic         w_skid_load;
            logic         w_skid_unload;
            logic         w_unused_skid_valid;
            logic [L-1:0] w_skid_data;

            assign w_in          = p.valid_f && r_ready_f;
            assign w_out         = r_valid_b && p.ready_b;
            assign w_skid_load   = (r_state == ST_ONE) && w_in && !w_out;
            assign w_skid_unload = (r_state == ST_TWO) && w_out;

            pipe_skid_reg #(.L(L)) u_skid (
                .clk      (clk),
                .rst      (rst),
                .i_clr    (w_flush),
                .i_load   (w_skid_load),
                .i_unload (w_skid_unload),
                .i_data   (p.data_f),
                .o_data   (w_skid_data),
                .o_valid  (w_unused_skid_valid)
            );

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state   <= ST_EMPTY;
                    r_ready_f <= 1'b1;
                    r_valid_b <= 1'b0;
                    r_data    <= '0;
                end else if (w_flush) begin
                    r_state   <= ST_EMPTY;
                    r_ready_f <= 1'b1;
                    r_valid_b <= 1'b0;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_in) begin
                                r_state   <= ST_ONE;
                                r_valid_b <= 1'b1;
                                r_data    <= p.data_f;
                            end
                        end
                        ST_ONE: begin
                            if (w_in && !w_out) begin
                                r_state   <= ST_TWO;
                                r_ready_f <= 1'b0;
                            end else if (w_out && !w_in) begin
                                r_state   <= ST_EMPTY;
                                r_valid_b <= 1'b0;
                            end else if (w_in && w_out) begin
                                r_data    <= p.data_f;
                            end
                        end
                        ST_TWO: begin
                            // Skid word moves up to the output register.
                            if (w_out) begin
                                r_state   <= ST_ONE;
                                r_ready_f <= 1'b1;
                                r_data    <= w_skid_data;
                            end
                        end
                        default: begin
                            r_state   <= ST_EMPTY;
                            r_ready_f <= 1'b1;
                            r_valid_b <= 1'b0;
                        end
                    endcase
                end
            end

            assign p.ready_f = r_ready_f;
            assign p.valid_b = r_valid_b;
            assign p.data_b  = r_data;
            assign p.occ     = occ_of(r_state);
        end
    endgenerate

endmodule
`default_nettype wire
